// File: rtl/vc32_mem_pkg.sv
// Shared types and constants for the quad-bus arbiter/sequencer (icache_mem_arb).
// Bus commands, phase lengths, FSM state and grant encodings live here.
package vc32_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_END   = 3'd5,
    ST_REJ   = 3'd6
  } state_t;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_DATA   = 1'b1
  } gnt_t;

  localparam logic [7:0] CMD_READ     = 8'hEB;
  localparam logic [7:0] CMD_WRITE    = 8'h38;
  localparam int         ADDR_NIBBLES = 6;

  function automatic logic [7:0] cmd_byte(input logic wr);
    return wr ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/mem_nibble_shifter.sv
// 32-bit load/shift register: emits its top nibble MSN-first and shifts bus
// nibbles in at the bottom, so one register serves both directions.
module mem_nibble_shifter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        shift,
  input  logic [3:0]  din,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[27:0], din};
    end
  end

endmodule

// File: rtl/icache_mem_arb.sv
// Arbitrates the quad memory bus between icache line fills and the data port and
// sequences CMD/ADDR/DUMMY/DATA/END. Writes are built only with VC32_DWRITE_EN.
module icache_mem_arb
  import vc32_mem_pkg::*;
#(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int DUMMY       = 4,
  parameter int CSH         = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                ic_pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   ic_tag,
  output logic                                ic_busy,
  output logic                                ic_wstrobe,
  output logic [3:0]                          ic_dread,
  input  logic                                d_req,
  input  logic                                d_we,
  input  logic [PA-2:0]                       d_addr,
  input  logic [15:0]                         d_wdata,
  output logic [15:0]                         d_rdata,
  output logic                                d_ack,
  output logic                                d_fault,
  output logic                                mem_cs_n,
  output logic                                mem_oe,
  output logic [3:0]                          mem_dout,
  input  logic [3:0]                          mem_din,
  output logic [2:0]                          dbg_state
);

  localparam int         OFFW      = $clog2(LINE_LENGTH);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);
  localparam logic [7:0] FILL_LAST = 8'(LINE_LENGTH * 2 - 1);
  localparam logic [7:0] WORD_LAST = 8'd3;
  localparam logic [7:0] CSH_LAST  = 8'(CSH - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  gnt_t        grant, last_grant;
  logic        is_wr;
  logic        phase_last;
  logic        ic_win, d_win, grant_now;
  logic        sh_load, sh_shift;
  logic [31:0] sh_load_val, q;
  logic [PA-1:0] addr_pa;
  logic [7:0]  cmd;
  logic        unused_bits;

  // Data port handshake: d_req is a level held with d_we/d_addr/d_wdata until the
  // one-cycle d_ack; each d_ack retires exactly one request, d_fault qualifies it.
  assign ic_win    = ic_pull && (!d_req || last_grant == GNT_DATA);
  assign d_win     = d_req && !ic_win;
  assign grant_now = (state == ST_IDLE) && (ic_win || d_win);

  always_comb begin
    phase_last = 1'b0;
    case (state)
      ST_CMD:   phase_last = (cnt == 8'd1);
      ST_ADDR:  phase_last = (cnt == ADDR_LAST);
      ST_DUMMY: phase_last = (cnt == DUMMY_LAST);
      ST_DATA:  phase_last = (cnt == ((grant == GNT_ICACHE) ? FILL_LAST : WORD_LAST));
      ST_END:   phase_last = (cnt == CSH_LAST);
      default:  phase_last = 1'b0;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (grant_now) begin
`ifdef VC32_DWRITE_EN
          state_nx = ST_CMD;
`else
          state_nx = (d_win && d_we) ? ST_REJ : ST_CMD;
`endif
        end
      end
      ST_CMD:   if (phase_last) state_nx = ST_ADDR;
      ST_ADDR: begin
        if (phase_last) begin
`ifdef VC32_DWRITE_EN
          state_nx = is_wr ? ST_DATA : ST_DUMMY;
`else
          state_nx = ST_DUMMY;
`endif
        end
      end
      ST_DUMMY: if (phase_last) state_nx = ST_DATA;
      ST_DATA:  if (phase_last) state_nx = ST_END;
      ST_END:   if (phase_last) state_nx = ST_IDLE;
      ST_REJ:   state_nx = ST_END;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (state != ST_IDLE) begin
      cnt <= cnt + 8'd1;
    end
  end

  // last_grant starts at DATA so the icache wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= GNT_ICACHE;
      last_grant <= GNT_DATA;
      is_wr      <= 1'b0;
    end else if (grant_now) begin
      grant      <= ic_win ? GNT_ICACHE : GNT_DATA;
      last_grant <= ic_win ? GNT_ICACHE : GNT_DATA;
      is_wr      <= d_win && d_we;
    end
  end

  // ---------------- shifter control ----------------
  assign addr_pa = ic_win ? {ic_tag, {OFFW{1'b0}}} : {d_addr, 1'b0};

`ifdef VC32_DWRITE_EN
  assign cmd = cmd_byte(d_win && d_we);
  // Write data is reloaded at the end of ADDR in bus byte order: low byte first.
  assign sh_load = grant_now || (state == ST_ADDR && phase_last && is_wr);
  assign sh_load_val = (state == ST_IDLE) ? {cmd, 24'(addr_pa)}
                                          : {d_wdata[7:0], d_wdata[15:8], 16'h0000};
  assign unused_bits = ^q[27:16];
`else
  assign cmd = CMD_READ;
  assign sh_load = grant_now;
  assign sh_load_val = {cmd, 24'(addr_pa)};
  assign unused_bits = ^{q[27:16], d_wdata};
`endif

  assign sh_shift = (state != ST_IDLE);

  mem_nibble_shifter u_shifter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .din      (mem_din),
    .q        (q)
  );

  // ---------------- FSM: outputs ----------------
  // Fill reorder: the low nibble is strobed straight from the pins, the high nibble
  // (already shifted into q[7:4]) follows next cycle, keeping strobes gap-free.
  always_comb begin
    mem_cs_n   = 1'b1;
    mem_oe     = 1'b0;
    mem_dout   = 4'h0;
    ic_wstrobe = 1'b0;
    ic_dread   = 4'h0;
    d_ack      = 1'b0;
    d_fault    = 1'b0;
    d_rdata    = 16'h0000;
    ic_busy    = (state != ST_IDLE) && (grant == GNT_ICACHE) &&
                 !(state == ST_END && cnt != 8'd0);
    case (state)
      ST_CMD, ST_ADDR: begin
        mem_cs_n = 1'b0;
        mem_oe   = 1'b1;
        mem_dout = q[31:28];
      end
      ST_DUMMY: mem_cs_n = 1'b0;
      ST_DATA: begin
        mem_cs_n = 1'b0;
`ifdef VC32_DWRITE_EN
        if (is_wr) begin
          mem_oe   = 1'b1;
          mem_dout = q[31:28];
        end
`endif
        if (grant == GNT_ICACHE) begin
          if (cnt[0]) begin
            ic_wstrobe = 1'b1;
            ic_dread   = mem_din;
          end else if (cnt != 8'd0) begin
            ic_wstrobe = 1'b1;
            ic_dread   = q[7:4];
          end
        end
      end
      ST_END: begin
        if (cnt == 8'd0) begin
          if (grant == GNT_ICACHE) begin
            ic_wstrobe = 1'b1;
            ic_dread   = q[7:4];
          end else begin
            d_ack = 1'b1;
`ifndef VC32_DWRITE_EN
            d_fault = is_wr;
`endif
            if (!is_wr) d_rdata = {q[7:0], q[15:8]};
          end
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_icache_mem_arb.sv
// Directed bench for icache_mem_arb: fills, data read/write (VC32_DWRITE_EN aware),
// contention ordering and asynchronous reset mid-fill, with a nibble-bus memory.
module tb_icache_mem_arb;
  import vc32_mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        ic_pull;
  logic [19:0] ic_tag;
  logic        ic_busy, ic_wstrobe;
  logic [3:0]  ic_dread;
  logic        d_req, d_we;
  logic [20:0] d_addr;
  logic [15:0] d_wdata, d_rdata;
  logic        d_ack, d_fault;
  logic        mem_cs_n, mem_oe;
  logic [3:0]  mem_dout, mem_din;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  icache_mem_arb #(.PA(22), .LINE_LENGTH(4), .DUMMY(4), .CSH(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_pull(ic_pull), .ic_tag(ic_tag), .ic_busy(ic_busy),
    .ic_wstrobe(ic_wstrobe), .ic_dread(ic_dread),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_fault(d_fault),
    .mem_cs_n(mem_cs_n), .mem_oe(mem_oe), .mem_dout(mem_dout), .mem_din(mem_din),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Quad memory responder: logs cmd/addr/write nibbles and answers 0xEB reads.
  logic [7:0]  mem [0:1023];
  int          bus_n = 0;
  logic [31:0] bus_cmd_addr = '0;
  logic [15:0] bus_wdata = '0;

  always @(posedge clk) begin
    int i, a;
    logic [7:0] b;
    #1;
    if (mem_cs_n) begin
      bus_n = 0;
      mem_din = 4'h0;
    end else begin
      if (bus_n < 8) bus_cmd_addr = {bus_cmd_addr[27:0], mem_dout};
      else if (mem_oe) bus_wdata = {bus_wdata[11:0], mem_dout};
      mem_din = 4'h0;
      if (bus_n >= 12 && bus_cmd_addr[31:24] == 8'hEB) begin
        i = bus_n - 12;
        a = int'(bus_cmd_addr[9:0]) + i / 2;
        b = mem[a];
        mem_din = (i % 2 == 0) ? b[7:4] : b[3:0];
      end
      bus_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] nibs);
    for (int i = 7; i >= 0; i--) exp_q.push_back(nibs[i*4 +: 4]);
  endtask

  task automatic take_strobe();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check("strobe_unexpected", 32'(ic_dread), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("fill_nibble", 32'(ic_dread), 32'(e));
    end
  endtask

  task automatic do_fill(input logic [19:0] tag, input logic [31:0] nibs, input logic [31:0] exp_bus);
    int first_s, last_s, n_s;
    first_s = -1; last_s = -1; n_s = 0;
    push_line(nibs);
    @(negedge clk);
    ic_pull = 1'b1;
    ic_tag  = tag;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("fill_busy_c1", 32'(ic_busy), 32'd1);
        check("fill_cs_low_c1", 32'(mem_cs_n), 32'd0);
        ic_pull = 1'b0;
      end
      if (k == 21) begin
        check("fill_busy_c21", 32'(ic_busy), 32'd1);
        check("fill_cs_high_c21", 32'(mem_cs_n), 32'd1);
      end
      if (k == 22) begin
        check("fill_busy_c22", 32'(ic_busy), 32'd0);
        check("fill_idle_c22", 32'(dbg_state), 32'(ST_IDLE));
      end
      if (ic_wstrobe) begin
        if (first_s < 0) first_s = k;
        last_s = k;
        n_s++;
        take_strobe();
      end
    end
    check("fill_first_strobe", 32'(first_s), 32'd14);
    check("fill_last_strobe", 32'(last_s), 32'd21);
    check("fill_strobe_count", 32'(n_s), 32'd8);
    check("fill_cmd_addr", bus_cmd_addr, exp_bus);
  endtask

  task automatic do_dread(input logic [20:0] addr, input logic [15:0] exp_data, input logic [31:0] exp_bus);
    int ack_k, n_ack;
    logic [15:0] rd;
    logic flt;
    ack_k = -1; n_ack = 0; rd = '0; flt = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = addr;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_ack) begin
        ack_k = k; n_ack++; rd = d_rdata; flt = d_fault;
        d_req = 1'b0;
      end
    end
    check("dread_ack_cycle", 32'(ack_k), 32'd17);
    check("dread_ack_count", 32'(n_ack), 32'd1);
    check("dread_rdata", 32'(rd), 32'(exp_data));
    check("dread_fault", 32'(flt), 32'd0);
    check("dread_cmd_addr", bus_cmd_addr, exp_bus);
  endtask

  task automatic do_dwrite(input logic [20:0] addr, input logic [15:0] data);
    int ack_k, n_cs;
    logic flt;
    ack_k = -1; n_cs = 0; flt = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (!mem_cs_n) n_cs++;
      if (d_ack) begin
        ack_k = k; flt = d_fault;
        d_req = 1'b0;
      end
    end
    d_we = 1'b0;
`ifdef VC32_DWRITE_EN
    check("dwrite_ack_cycle", 32'(ack_k), 32'd13);
    check("dwrite_fault", 32'(flt), 32'd0);
    check("dwrite_cs_cycles", 32'(n_cs), 32'd12);
    check("dwrite_cmd_addr", bus_cmd_addr, 32'h3800_0204);
    check("dwrite_data_nibbles", 32'(bus_wdata), 32'h0000_EFBE);
`else
    check("dwrite_rej_ack_cycle", 32'(ack_k), 32'd2);
    check("dwrite_rej_fault", 32'(flt), 32'd1);
    check("dwrite_rej_no_bus", 32'(n_cs), 32'd0);
`endif
  endtask

  initial begin
    int run, min_gap, n_gnt, n_ack, n_s;
    logic started, prev_cs;
    logic [3:0] gnt_seen;
    int ack_exp [2];

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h040] = 8'h12; mem[10'h041] = 8'h34; mem[10'h042] = 8'h56; mem[10'h043] = 8'h78;
    mem[10'h044] = 8'h9A; mem[10'h045] = 8'hBC; mem[10'h046] = 8'hDE; mem[10'h047] = 8'hF0;
    mem[10'h204] = 8'hCD; mem[10'h205] = 8'hAB;

    reset_n = 1'b0; ic_pull = 1'b0; ic_tag = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(mem_cs_n), 32'd1);
    check("rst_outputs", {26'(0), ic_busy, ic_wstrobe, d_ack, d_fault, mem_oe, |mem_dout}, 32'd0);
    check("rst_rdata_dread", {12'(0), d_rdata, ic_dread}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // contention from reset: icache first, then grants alternate
    ack_exp[0] = 39; ack_exp[1] = 79;
    run = 0; min_gap = 1000; n_gnt = 0; n_ack = 0; n_s = 0;
    started = 1'b0; prev_cs = 1'b1; gnt_seen = '0;
    push_line(32'h2143_6587);
    push_line(32'h2143_6587);
    ic_pull = 1'b1; ic_tag = 20'h00010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 21'h000102;
    for (int k = 1; k <= 85; k++) begin
      @(negedge clk);
      if (!mem_cs_n) begin
        if (prev_cs) begin
          if (n_gnt < 4) gnt_seen[3 - n_gnt] = ic_busy;
          n_gnt++;
          if (started && run < min_gap) min_gap = run;
        end
        started = 1'b1;
        run = 0;
      end else begin
        run++;
      end
      prev_cs = mem_cs_n;
      if (ic_wstrobe) begin
        n_s++;
        take_strobe();
      end
      if (d_ack) begin
        if (n_ack < 2) check("cont_ack_cycle", 32'(k), 32'(ack_exp[n_ack]));
        check("cont_rdata", 32'(d_rdata), 32'h0000_ABCD);
        n_ack++;
      end
      if (k == 79) begin
        ic_pull = 1'b0;
        d_req = 1'b0;
      end
    end
    check("cont_grant_order", 32'(gnt_seen), 32'b1010);
    check("cont_grant_count", 32'(n_gnt), 32'd4);
    check("cont_ack_count", 32'(n_ack), 32'd2);
    check("cont_strobe_count", 32'(n_s), 32'd16);
    check("cont_min_cs_high", 32'(min_gap), 32'd2);

    // single requests
    do_fill(20'h00010, 32'h2143_6587, 32'hEB00_0040);
    do_dread(21'h000102, 16'hABCD, 32'hEB00_0204);
    do_dwrite(21'h000102, 16'hBEEF);

    // asynchronous reset in the middle of a fill
    @(negedge clk);
    ic_pull = 1'b1; ic_tag = 20'h00010;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) ic_pull = 1'b0;
    end
    check("abort_pre_strobe", 32'(ic_wstrobe), 32'd1);
    check("abort_pre_dread", 32'(ic_dread), 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(mem_cs_n), 32'd1);
    check("abort_wstrobe", 32'(ic_wstrobe), 32'd0);
    check("abort_busy_oe", {30'(0), ic_busy, mem_oe}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_fill(20'h00011, 32'hA9CB_ED0F, 32'hEB00_0044);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_mem_arb.md
# icache_mem_arb

Arbiter and sequencer sharing one nibble-wide (quad) external memory bus between the instruction-cache line fill port and the data load/store port. It grants one requester per transaction and runs the command/address/dummy/data phases on the bus. Read nibbles are reordered into the cache's low-nibble-first contiguous fill stream (`ic_wstrobe`/`ic_dread`), and 16-bit data words are assembled or serialized for the data port. It sits between the `icache` and the memory pads.

## Interface
- `PA`, 22: physical address width (bits).
- `LINE_LENGTH`, 4: cache line bytes; fill length is `LINE_LENGTH*2` nibbles.
- `DUMMY`, 4: read dummy cycles.
- `CSH`, 1: minimum `mem_cs_n` high cycles between transactions (≥1).
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `ic_pull` in 1: icache miss; line fill requested.
- `ic_tag` in `PA-clog2(LINE_LENGTH)`: line address (`PA-1:clog2(LINE_LENGTH)`).
- `ic_busy` out 1: fill granted/in progress; fetch holds `paddr` stable.
- `ic_wstrobe` out 1: fill nibble strobe to icache `wstrobe_d`.
- `ic_dread` out 4: fill nibble to icache `dread`.
- `d_req` in 1: data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ack`.
- `d_we` in 1: 1 = write.
- `d_addr` in `PA-1`: halfword address (`PA-1:1`).
- `d_wdata` in 16: write data.
- `d_rdata` out 16: read data, valid with `d_ack`.
- `d_ack` out 1: one-cycle completion pulse.
- `d_fault` out 1: valid with `d_ack`; request rejected.
- `mem_cs_n` out 1: bus select.
- `mem_oe` out 1: 1 = `mem_dout` drives pads.
- `mem_dout` out 4: nibble out.
- `mem_din` in 4: nibble in, sampled at the clock edge.

## Operation
- States: IDLE, CMD (2 cycles), ADDR (6), DUMMY (`DUMMY`, reads only), DATA (`LINE_LENGTH*2` or 4 nibbles), END (`CSH`).
- IDLE arbitration:
  - A single pending requester wins.
  - If both are pending, the grant goes to the requester not granted last. `last_grant` resets to DATA, so the icache wins the first tie.
  - `ic_pull` is sampled only in IDLE. Dropping it mid-fill is ignored and the fill completes.
- Command byte is sent high nibble first: read 0xEB, write 0x38.
- Address is 24-bit, sent MSN first, zero-extended from PA bits.
  - icache: `{ic_tag, clog2(LINE_LENGTH)'b0}`.
  - data: `{d_addr, 1'b0}`.
- `mem_oe` = 1 in CMD/ADDR/write-DATA. It is 0 in DUMMY, read-DATA, END and IDLE.
- Memory byte order is ascending. Each byte is transferred high nibble first.
- icache fill reorder:
  - On a byte's high nibble, hold it.
  - On the low nibble, strobe the low nibble.
  - Next cycle, strobe the held high nibble.
  - Result: strobes are contiguous for exactly `LINE_LENGTH*2` cycles. There must be no gap, because the icache offset clears on a strobe gap.
- Data read: byte0 → `d_rdata[7:0]`, byte1 → `[15:8]`.
- Data write: `d_wdata[7:4]`, `[3:0]`, `[15:12]`, `[11:8]`.
- `ic_busy` is high from the grant cycle through the last strobe.
- Reset values: `mem_cs_n`=1; all other outputs 0.
  - Reset assertion mid-transaction forces these values immediately (asynchronously) and aborts the transaction.
  - After an abort the icache line stays invalid.

## Timing
- Request seen in IDLE at cycle 0 → CMD cycles 1–2, `mem_cs_n` low from cycle 1.
- ADDR: cycles 3–8.
- icache read:
  - DUMMY 9–12.
  - `mem_din` sampled 13–20.
  - `ic_wstrobe` 14–21.
  - END from 21, with `mem_cs_n` high.
  - IDLE at 21+`CSH`.
- Data read: sampled 13–16; `d_ack` at 17 (first END cycle).
- Data write: DATA 9–12; `d_ack` at 13.
- Back-to-back requests: the next CMD starts one cycle after END. This gives a `CSH`+1 cycle minimum `mem_cs_n` high time.

## Configuration
- `VC32_DWRITE_EN`:
  - Defined: writes run as above and `d_fault` is always 0.
  - Undefined: a granted `d_we`=1 request produces `d_ack`=1 and `d_fault`=1 in the cycle after grant, with no bus activity (`mem_cs_n` stays 1). The write-DATA path and command 0x38 are not synthesized.

## Structure
- Package `vc32_mem_pkg` holds:
  - state enum;
  - `CMD_READ`=8'hEB and `CMD_WRITE`=8'h38;
  - `ADDR_NIBBLES`=6;
  - the grant-type enum (ICACHE/DATA).
- Sub-module `mem_nibble_shifter`: 32-bit load/shift register that serializes cmd/addr/wdata MSN-first and deserializes read nibbles. The controller instantiates one.

## Test plan
- icache `ic_pull`, `ic_tag`=20'h00010; memory bytes 0x12,0x34,0x56,0x78 at 0x40 → addr nibbles 0,0,0,0,4,0; `ic_dread` sequence 2,1,4,3,6,5,8,7 on 8 contiguous strobes, cycles 14–21.
- Data read `d_addr`=21'h000102 with bytes 0xCD,0xAB at 0x204 → `d_rdata`=16'hABCD, `d_ack` at cycle 17, `d_fault`=0.
- `VC32_DWRITE_EN` write `d_wdata`=16'hBEEF → `mem_dout` 3,8,addr…,E,F,B,E; `d_ack` at 13. Without the macro: `d_ack`+`d_fault` at cycle 2, `mem_cs_n` stays 1.
- `ic_pull` and `d_req` together from reset → icache first, then data. Repeated contention alternates grants; `mem_cs_n` high ≥2 cycles between transactions.
- `reset_n` low at DATA cycle 15 of a fill → `mem_cs_n`=1 and `ic_wstrobe`=0 immediately. After release, a new `ic_pull` refills the full line correctly.
